// File: rtl/osc_tick_pkg.sv
// -----------------------------------------------------------------------------
// osc_tick_pkg
// Shared types and helpers for the oscillator tick generator.
//   osc_state_e   : main FSM state encoding (SETTLE, RUN, RELOAD)
//   TICK_CNT_W    : width of the optional tick counter (OSC_TICK_GEN_CNT_EN)
//   settle_cnt_w(): bits needed to count 0 .. STARTUP_CYCLES-1
// -----------------------------------------------------------------------------
package osc_tick_pkg;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        RUN    = 2'd1,
        RELOAD = 2'd2
    } osc_state_e;

    localparam int TICK_CNT_W = 32;

    // A window of one cycle still needs a 1-bit counter.
    function automatic int settle_cnt_w(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/osc_tick_gen_if.sv
// -----------------------------------------------------------------------------
// osc_tick_gen_if
// Divide-ratio reload handshake between a requester (master) and the tick
// generator (slave).
//   div_val : requested divide ratio N          (master -> slave)
//   div_req : load request, held until div_ack  (master -> slave)
//   div_ack : one-cycle acknowledge             (slave -> master)
//   div_err : with div_ack, 1 = rejected (N==0) (slave -> master)
// -----------------------------------------------------------------------------
interface osc_tick_gen_if #(
    parameter int DIV_W = 16
);
    logic [DIV_W-1:0] div_val;
    logic             div_req;
    logic             div_ack;
    logic             div_err;

    modport master (output div_val, output div_req, input div_ack, input div_err);
    modport slave  (input div_val, input div_req, output div_ack, output div_err);
endinterface

// File: rtl/osc_div_handshake.sv
// -----------------------------------------------------------------------------
// osc_div_handshake
// Accepts divide-ratio requests, acknowledges them for one cycle, rejects a
// zero ratio and holds the ratio currently in force.
//   clk, rst_n   : clock / async active-low reset
//   div_val_i    : requested ratio
//   div_req_i    : request (sampled while ack is low)
//   accept_en_i  : requests may be accepted this cycle
//   div_ack_o    : one-cycle acknowledge
//   div_err_o    : rejection flag, meaningful with div_ack_o
//   cur_div_o    : ratio in force
//   load_o       : combinational strobe, high on the edge a nonzero ratio loads
// -----------------------------------------------------------------------------
module osc_div_handshake #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div_val_i,
    input  logic             div_req_i,
    input  logic             accept_en_i,
    output logic             div_ack_o,
    output logic             div_err_o,
    output logic [DIV_W-1:0] cur_div_o,
    output logic             load_o
);

    logic             div_ack_q;
    logic             div_err_q;
    logic [DIV_W-1:0] cur_div_q;
    logic [DIV_W-1:0] cur_div_d;
    logic             accept;
    logic             val_ok;

    // A request still high in the ack cycle is ignored; one cycle later it is new.
    assign accept    = div_req_i && !div_ack_q && accept_en_i;
    assign val_ok    = (div_val_i != '0);
    assign load_o    = accept && val_ok;
    assign cur_div_d = load_o ? div_val_i : cur_div_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_ack_q <= 1'b0;
            div_err_q <= 1'b0;
            cur_div_q <= DIV_W'(DEFAULT_DIV);
        end else begin
            div_ack_q <= accept;
            div_err_q <= accept && !val_ok;
            cur_div_q <= cur_div_d;
        end
    end

    assign div_ack_o = div_ack_q;
    assign div_err_o = div_err_q;
    assign cur_div_o = cur_div_q;

endmodule

// File: rtl/osc_tick_gen.sv
// -----------------------------------------------------------------------------
// osc_tick_gen
// Consumer of the on-chip oscillator clock: waits out a settling window after
// reset, then emits a one-cycle tick every cur_div cycles. The ratio can be
// reloaded at run time through the div_if handshake.
//   clk, rst_n : oscillator clock / async active-low reset
//   div_if     : reload handshake (slave side)
//   ready      : settling complete, ticks running
//   tick       : one-cycle pulse every cur_div cycles while ready
//   cur_div    : ratio in force
//   tick_cnt   : count of tick cycles, present only with OSC_TICK_GEN_CNT_EN
//
// state  | meaning
// SETTLE | oscillator settling, no ticks, reloads update cur_div only
// RUN    | period counter running, tick after count == cur_div-1
// RELOAD | one cycle after a nonzero reload: counter cleared, tick low
// -----------------------------------------------------------------------------
module osc_tick_gen
    import osc_tick_pkg::*;
#(
    parameter int STARTUP_CYCLES = 1024,
    parameter int DIV_W          = 16,
    parameter int DEFAULT_DIV    = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    osc_tick_gen_if.slave         div_if,
    output logic                  ready,
    output logic                  tick,
    output logic [DIV_W-1:0]      cur_div
`ifdef OSC_TICK_GEN_CNT_EN
    ,
    output logic [TICK_CNT_W-1:0] tick_cnt
`endif
);

    localparam int                  SETTLE_W    = settle_cnt_w(STARTUP_CYCLES);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(STARTUP_CYCLES - 1);

    osc_state_e          state_q;
    logic [SETTLE_W-1:0] settle_q;
    logic [DIV_W-1:0]    pcnt_q;
    logic                ready_q;
    logic                tick_q;
    logic [DIV_W-1:0]    cur_div_w;
    logic [DIV_W-1:0]    last_cnt;
    logic                load;
    logic                period_end;

    osc_div_handshake #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_hs (
        .clk         (clk),
        .rst_n       (rst_n),
        .div_val_i   (div_if.div_val),
        .div_req_i   (div_if.div_req),
        .accept_en_i (state_q != RELOAD),
        .div_ack_o   (div_if.div_ack),
        .div_err_o   (div_if.div_err),
        .cur_div_o   (cur_div_w),
        .load_o      (load)
    );

    // cur_div >= 1 always, so this never underflows.
    assign last_cnt   = cur_div_w - DIV_W'(1);
    assign period_end = (pcnt_q == last_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SETTLE;
            settle_q <= '0;
            pcnt_q   <= '0;
            ready_q  <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            unique case (state_q)
                SETTLE: begin
                    tick_q <= 1'b0;
                    pcnt_q <= '0;
                    if (settle_q == SETTLE_LAST) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end else begin
                        settle_q <= settle_q + SETTLE_W'(1);
                    end
                end
                RUN: begin
                    // A tick due on the acceptance edge is still issued; RELOAD follows.
                    tick_q <= period_end;
                    pcnt_q <= period_end ? '0 : pcnt_q + DIV_W'(1);
                    if (load) begin
                        state_q <= RELOAD;
                    end
                end
                RELOAD: begin
                    tick_q  <= 1'b0;
                    pcnt_q  <= '0;
                    state_q <= RUN;
                end
                default: begin
                    tick_q  <= 1'b0;
                    pcnt_q  <= '0;
                    state_q <= SETTLE;
                end
            endcase
        end
    end

    assign ready   = ready_q;
    assign tick    = tick_q;
    assign cur_div = cur_div_w;

`ifdef OSC_TICK_GEN_CNT_EN
    logic [TICK_CNT_W-1:0] tick_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else if (tick_q) begin
            tick_cnt_q <= tick_cnt_q + TICK_CNT_W'(1);
        end
    end

    assign tick_cnt = tick_cnt_q;
`endif

endmodule

// File: tb/tb_osc_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_osc_tick_gen
// Directed bench for osc_tick_gen with STARTUP_CYCLES=16, DEFAULT_DIV=4.
// Inputs change and outputs are sampled on the falling clock edge.
// The tick_cnt wrap step is included when OSC_TICK_GEN_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_osc_tick_gen;
    import osc_tick_pkg::*;

    localparam int DIV_W = 16;

    logic             clk;
    logic             rst_n;
    logic             ready;
    logic             tick;
    logic [DIV_W-1:0] cur_div;
`ifdef OSC_TICK_GEN_CNT_EN
    logic [TICK_CNT_W-1:0] tick_cnt;
`endif

    int checks = 0;
    int errors = 0;

    osc_tick_gen_if #(.DIV_W(DIV_W)) div_if ();

    osc_tick_gen #(
        .STARTUP_CYCLES (16),
        .DIV_W          (DIV_W),
        .DEFAULT_DIV    (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .div_if  (div_if.slave),
        .ready   (ready),
        .tick    (tick),
        .cur_div (cur_div)
`ifdef OSC_TICK_GEN_CNT_EN
        ,
        .tick_cnt (tick_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bit i of pat = tick after the i-th of the next n rising edges.
    task automatic rec(input int n, output logic [31:0] pat);
        pat = '0;
        for (int i = 0; i < n; i++) begin
            cyc();
            pat[i] = tick;
        end
    endtask

    logic [31:0] pat;
    logic        seen;

    initial begin
        rst_n          = 1'b0;
        div_if.div_req = 1'b0;
        div_if.div_val = '0;
        repeat (2) cyc();

        // reset values
        chk("rst_ready",   32'(ready), 32'd0);
        chk("rst_tick",    32'(tick), 32'd0);
        chk("rst_ack",     32'(div_if.div_ack), 32'd0);
        chk("rst_err",     32'(div_if.div_err), 32'd0);
        chk("rst_cur_div", 32'(cur_div), 32'd4);

        // settling: ready after the 16th edge, no tick before
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            cyc();
            seen = seen | tick;
        end
        chk("settle_no_tick", 32'(seen), 32'd0);
        chk("settle_ready_15", 32'(ready), 32'd0);
        cyc();
        chk("settle_ready_16", 32'(ready), 32'd1);
        chk("settle_tick_16", 32'(tick), 32'd0);
        rec(12, pat);
        chk("run_div4_ticks", pat, 32'h888);

        // reload to 7 (counter at 0, no tick due)
        div_if.div_val = 16'd7;
        div_if.div_req = 1'b1;
        cyc();
        chk("rl7_ack", 32'(div_if.div_ack), 32'd1);
        chk("rl7_err", 32'(div_if.div_err), 32'd0);
        chk("rl7_cur_div", 32'(cur_div), 32'd7);
        chk("rl7_tick", 32'(tick), 32'd0);
        div_if.div_req = 1'b0;
        cyc();
        chk("rl7_ack_drop", 32'(div_if.div_ack), 32'd0);
        chk("rl7_reload_tick", 32'(tick), 32'd0);
        rec(14, pat);
        chk("run_div7_ticks", pat, 32'h2040);

        // zero request: rejected, spacing unchanged
        div_if.div_val = 16'd0;
        div_if.div_req = 1'b1;
        cyc();
        chk("zero_ack", 32'(div_if.div_ack), 32'd1);
        chk("zero_err", 32'(div_if.div_err), 32'd1);
        chk("zero_cur_div", 32'(cur_div), 32'd7);
        div_if.div_req = 1'b0;
        cyc();
        chk("zero_ack_drop", 32'(div_if.div_ack), 32'd0);
        rec(12, pat);
        chk("zero_div7_ticks", pat, 32'h810);

        // acceptance on the edge a tick is due: tick kept, reload follows
        repeat (6) cyc();
        chk("pre_sim_tick", 32'(tick), 32'd0);
        div_if.div_val = 16'd3;
        div_if.div_req = 1'b1;
        cyc();
        chk("sim_tick_kept", 32'(tick), 32'd1);
        chk("sim_ack", 32'(div_if.div_ack), 32'd1);
        chk("sim_cur_div", 32'(cur_div), 32'd3);
        div_if.div_req = 1'b0;
        cyc();
        chk("sim_reload_tick", 32'(tick), 32'd0);
        rec(6, pat);
        chk("run_div3_ticks", pat, 32'h24);

        // request during SETTLE, N=1 -> continuous tick
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        div_if.div_val = 16'd1;
        div_if.div_req = 1'b1;
        cyc();
        chk("set_ack", 32'(div_if.div_ack), 32'd1);
        chk("set_err", 32'(div_if.div_err), 32'd0);
        chk("set_cur_div", 32'(cur_div), 32'd1);
        chk("set_ready", 32'(ready), 32'd0);
        div_if.div_req = 1'b0;
        repeat (11) cyc();
        chk("set_ready_15", 32'(ready), 32'd0);
        cyc();
        chk("set_ready_16", 32'(ready), 32'd1);
        chk("set_tick_16", 32'(tick), 32'd0);
        rec(8, pat);
        chk("run_div1_ticks", pat, 32'hFF);

        // reset mid-settle with a request pending: dropped, full window again
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        repeat (5) cyc();
        div_if.div_val = 16'd9;
        div_if.div_req = 1'b1;
        rst_n          = 1'b0;
        cyc();
        chk("mrst_ack", 32'(div_if.div_ack), 32'd0);
        chk("mrst_cur_div", 32'(cur_div), 32'd4);
        chk("mrst_ready", 32'(ready), 32'd0);
        rst_n          = 1'b1;
        div_if.div_req = 1'b0;
        seen = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            cyc();
            seen = seen | ready | div_if.div_ack;
        end
        chk("mrst_no_ready_ack", 32'(seen), 32'd0);
        cyc();
        chk("mrst_ready_16", 32'(ready), 32'd1);
        chk("mrst_cur_div_16", 32'(cur_div), 32'd4);

`ifdef OSC_TICK_GEN_CNT_EN
        // tick counter wrap via backdoor preload
        chk("cnt_rst", tick_cnt, 32'd0);
        force dut.tick_cnt_q = 32'hFFFF_FFFE;
        cyc();
        release dut.tick_cnt_q;
        chk("cnt_preload", tick_cnt, 32'hFFFF_FFFE);
        repeat (3) cyc();
        cyc();
        chk("cnt_max", tick_cnt, 32'hFFFF_FFFF);
        repeat (3) cyc();
        cyc();
        chk("cnt_wrap", tick_cnt, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
